// File: rtl/pwm_prescaler_if.sv
// Prescaler control/pulse bundle: the timer core drives enable, preload and update, and receives the count-enable.
// Status views psc_cnt/psc_act exist only when PSC_STATUS_EN is defined.
interface pwm_prescaler_if #(
    parameter int PSC_WIDTH = 16
);
    logic                 cen;
    logic [PSC_WIDTH-1:0] psc_preload;
    logic                 ug;
    logic                 ck_cnt;
`ifdef PSC_STATUS_EN
    logic [PSC_WIDTH-1:0] psc_cnt;
    logic [PSC_WIDTH-1:0] psc_act;

    modport master (
        output cen, psc_preload, ug,
        input  ck_cnt, psc_cnt, psc_act
    );

    modport slave (
        input  cen, psc_preload, ug,
        output ck_cnt, psc_cnt, psc_act
    );
`else
    modport master (
        output cen, psc_preload, ug,
        input  ck_cnt
    );

    modport slave (
        input  cen, psc_preload, ug,
        output ck_cnt
    );
`endif
endinterface

// File: rtl/pwm_prescaler.sv
// Purpose: divides clk_psc_i by (PSC+1) with a double-buffered PSC and emits a one-cycle ck_cnt pulse.
// Latency: first pulse registered after edge PSC of an enabled run; no combinational input-to-output path.
// Backpressure: none, free-running while enabled; PSC_STATUS_EN adds live psc_cnt/psc_act register views.
module pwm_prescaler #(
    parameter int PSC_WIDTH = 16
) (
    input  logic              clk_psc_i,
    input  logic              rst_i,
    pwm_prescaler_if.slave    bus
);

    logic [PSC_WIDTH-1:0] cnt;
    logic [PSC_WIDTH-1:0] psc_act;
    logic                 ck_cnt_q;
    logic                 wrap;

    // Wrap by compare, never by overflow, so an all-ones PSC divides by 2^PSC_WIDTH.
    assign wrap = (cnt == psc_act);

    always_ff @(posedge clk_psc_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            psc_act  <= '0;
            ck_cnt_q <= 1'b0;
        end else if (bus.ug || !bus.cen) begin
            // Forced update and idle both restart the period and make the preload live.
            cnt      <= '0;
            psc_act  <= bus.psc_preload;
            ck_cnt_q <= 1'b0;
        end else if (wrap) begin
            cnt      <= '0;
            psc_act  <= bus.psc_preload;
            ck_cnt_q <= 1'b1;
        end else begin
            cnt      <= cnt + PSC_WIDTH'(1);
            ck_cnt_q <= 1'b0;
        end
    end

    assign bus.ck_cnt = ck_cnt_q;

`ifdef PSC_STATUS_EN
    assign bus.psc_cnt = cnt;
    assign bus.psc_act = psc_act;
`endif

endmodule

// File: tb/tb_pwm_prescaler.sv
// Directed bench for pwm_prescaler: divide, bypass, dynamic reload, ug/cen controls, all-ones PSC and async reset.
module tb_pwm_prescaler;

    logic clk_psc;
    logic rst;
    int   n_total;
    int   n_bad;
    int   npulse;
    int   pidx;

    pwm_prescaler_if #(.PSC_WIDTH(16)) bus ();

    pwm_prescaler #(.PSC_WIDTH(16)) dut (
        .clk_psc_i (clk_psc),
        .rst_i     (rst),
        .bus       (bus)
    );

    initial clk_psc = 1'b0;
    always #5 clk_psc = ~clk_psc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Steps n edges; ck_cnt is expected high on relative edge 'first' and every 'period' edges after it.
    task automatic expect_run(input string tag, input int n, input int first, input int period);
        time t_prev;
        bit  seen;
        bit  e;
        seen   = 1'b0;
        t_prev = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_psc);
            @(negedge clk_psc);
            e = (i >= first) && (((i - first) % period) == 0);
            chk($sformatf("%s[%0d]", tag, i), {31'd0, bus.ck_cnt}, {31'd0, e});
            if (e && bus.ck_cnt) begin
                if (seen && period > 1)
                    chk($sformatf("%s_gap", tag), 32'($time - t_prev), 32'(period * 10));
                t_prev = $time;
                seen   = 1'b1;
            end
        end
    endtask

    initial begin
        n_total         = 0;
        n_bad           = 0;
        rst             = 1'b1;
        bus.cen         = 1'b0;
        bus.ug          = 1'b0;
        bus.psc_preload = 16'd4;

        // Reset state, visible before any clock edge
        #1;
        chk("rst_ck0", {31'd0, bus.ck_cnt}, 32'd0);
`ifdef PSC_STATUS_EN
        chk("rst_cnt0", {16'd0, bus.psc_cnt}, 32'd0);
        chk("rst_act0", {16'd0, bus.psc_act}, 32'd0);
`endif
        @(negedge clk_psc);
        chk("rst_ck1", {31'd0, bus.ck_cnt}, 32'd0);
        rst = 1'b0;
        expect_run("idle", 3, 99, 1);
`ifdef PSC_STATUS_EN
        chk("idle_cnt", {16'd0, bus.psc_cnt}, 32'd0);
        chk("idle_act", {16'd0, bus.psc_act}, 32'd4);
`endif

        // PSC=4: pulses after edges 4, 9, 14, 19, spaced 50 time units
        bus.cen = 1'b1;
        expect_run("div4", 20, 4, 5);

        // Bypass: 4->0 written at cnt=2, old period still completes
        expect_run("b_pre", 2, 99, 1);
        bus.psc_preload = 16'd0;
        expect_run("b_old", 3, 2, 5);
        expect_run("b_byp", 4, 0, 1);
        bus.psc_preload = 16'd4;
        expect_run("b_rst", 6, 0, 5);

        // Dynamic 4->10 at cnt=2: one more 5-spacing, then 11-spacing
        expect_run("dy_pre", 2, 99, 1);
        bus.psc_preload = 16'd10;
        expect_run("dy_old", 3, 2, 5);
        expect_run("dy_new", 22, 10, 11);

        // ug mid-period at cnt=3 loads PSC=4 without a pulse
        bus.psc_preload = 16'd4;
        expect_run("ug_pre", 3, 99, 1);
        bus.ug = 1'b1;
        expect_run("ug_edge", 1, 99, 1);
`ifdef PSC_STATUS_EN
        chk("ug_cnt", {16'd0, bus.psc_cnt}, 32'd0);
        chk("ug_act", {16'd0, bus.psc_act}, 32'd4);
`endif
        bus.ug = 1'b0;
        expect_run("ug_post", 5, 4, 5);

        // ug coinciding with a wrap suppresses that pulse
        expect_run("w_pre", 4, 99, 1);
        bus.ug = 1'b1;
        expect_run("ug_wrap", 1, 99, 1);
        bus.ug = 1'b0;
        expect_run("w_post", 5, 4, 5);

        // cen dropped at cnt=2; preload changed while idle applies on re-enable
        expect_run("c_pre", 2, 99, 1);
`ifdef PSC_STATUS_EN
        chk("c_cnt2", {16'd0, bus.psc_cnt}, 32'd2);
`endif
        bus.cen = 1'b0;
        expect_run("c_idle", 3, 99, 1);
        bus.cen = 1'b1;
        expect_run("c_re4", 5, 4, 5);
        bus.cen = 1'b0;
        bus.psc_preload = 16'd2;
        expect_run("c_idle2", 2, 99, 1);
        bus.cen = 1'b1;
        expect_run("c_re2", 6, 2, 3);

        // All-ones PSC: one pulse per 65536 enabled edges, on the last one
        bus.cen = 1'b0;
        bus.psc_preload = 16'hFFFF;
        expect_run("ff_idle", 1, 99, 1);
        bus.cen = 1'b1;
        npulse = 0;
        pidx   = -1;
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk_psc);
            @(negedge clk_psc);
            if (bus.ck_cnt) begin
                npulse++;
                pidx = i;
            end
        end
        chk("ff_npulse", npulse, 32'd1);
        chk("ff_pos", pidx, 32'd65535);

        // Asynchronous reset mid-count (cnt=5)
        expect_run("ff_more", 5, 99, 1);
`ifdef PSC_STATUS_EN
        chk("ff_cnt5", {16'd0, bus.psc_cnt}, 32'd5);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ck", {31'd0, bus.ck_cnt}, 32'd0);
`ifdef PSC_STATUS_EN
        chk("arst_cnt", {16'd0, bus.psc_cnt}, 32'd0);
        chk("arst_act", {16'd0, bus.psc_act}, 32'd0);
`endif

        // After release behaves as from power-up
        @(negedge clk_psc);
        bus.cen         = 1'b0;
        bus.psc_preload = 16'd4;
        rst             = 1'b0;
        expect_run("pr_idle", 1, 99, 1);
        bus.cen = 1'b1;
        expect_run("pr", 5, 4, 5);

        // Reset while the pulse is high clears it without a clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hi", {31'd0, bus.ck_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
